chan_mem_arb: RTL and testbench
===============================

Name: chan_mem_arb

Overview:
Arbiter for the single-port per-channel state RAM in the MCAC control path. Three requesters share the RAM: the serial-input loader (sin, write), the functional-array operand fetch (far, read) and the functional-array writeback (faw, write). The block grants one access per cycle, drives the RAM port from registers, returns read data with a valid strobe, bounds serial-side starvation and flags protocol violations.

Parameters:
ADDR_W, 3, channel address width; 8 channels.
DATA_W, 16, RAM word width.
RD_LAT, 1, RAM read latency in clk cycles from mem_en to mem_rdata valid; legal range 1..4.
MAX_WAIT, 4, number of consecutive ungranted cycles with sin_req high before sin is promoted to top priority; legal range 1..15.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
sin_req  in  1  serial loader write request; held until sin_ack.
sin_addr  in  ADDR_W  serial write address.
sin_wdata  in  DATA_W  serial write data.
sin_ack  out  1  one-cycle grant/ack to serial loader.
far_req  in  1  FA read request; held until far_ack.
far_addr  in  ADDR_W  FA read address.
far_ack  out  1  one-cycle grant/ack for FA read.
far_rdata  out  DATA_W  read data; combinational pass-through of mem_rdata.
far_rvalid  out  1  one-cycle pulse when far_rdata is valid.
faw_req  in  1  FA writeback request; held until faw_ack.
faw_addr  in  ADDR_W  FA write address.
faw_wdata  in  DATA_W  FA write data.
faw_ack  out  1  one-cycle grant/ack to FA writeback.
mem_en  out  1  RAM access enable.
mem_we  out  1  RAM write enable; qualified by mem_en.
mem_addr  out  ADDR_W  RAM address.
mem_wdata  out  DATA_W  RAM write data.
mem_rdata  in  DATA_W  RAM read data.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all acks, mem_en, mem_we, far_rvalid and err are 0; mem_addr and mem_wdata are 0; wait counter is 0; read-valid pipe is cleared. Reset mid-operation aborts any pending far_rvalid; in-flight RAM reads are discarded.
- Arbitration is evaluated on the requests sampled at cycle N. At N+1 the arbiter registers the winner's ack, mem_en=1, mem_we, mem_addr and mem_wdata.
- Base priority: faw > far > sin.
- Promotion: wait_cnt increments each cycle sin_req=1 and sin is not granted, saturating at MAX_WAIT. It clears when sin is granted or sin_req=0. When wait_cnt==MAX_WAIT, sin has top priority.
- Re-grant mask: a requester whose ack is high in the current cycle is excluded from arbitration in that cycle, because its req is still visible. Each requester therefore gets at most one grant per 2 cycles. Other requesters may be granted back-to-back.
- Requesters drop req the cycle after ack. They may reassert at the following cycle.
- No requests: mem_en=0, mem_we=0, acks 0. mem_addr and mem_wdata hold their last value.
- Write grant (sin or faw): mem_we=1 and mem_wdata is the winner's wdata. Read grant (far): mem_we=0 and mem_wdata holds its last value.
- far_rvalid: asserted exactly RD_LAT cycles after the far_ack cycle, implemented as an RD_LAT-deep shift register. Overlapping reads are allowed and each produces its own pulse.
- Same-address ordering: if faw and far target the same address in the same cycle, faw wins, so the read that follows returns the new data.
- err is set (sticky until reset) on any of:
  - a req falling while that requester is not acked and was high the previous cycle (request withdrawn);
  - addr or wdata changing while req is held and not yet acked.

Test Plan:
1. Reset, then sin_req alone with addr=5, wdata=0x1234 -> next cycle sin_ack=1, mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0x1234; one access only.
2. faw, far and sin all asserted at cycle 0, each dropping req after its ack -> grants in order faw (cycle 1), far (cycle 2), sin (cycle 3); far_rvalid pulses at cycle 2+RD_LAT with far_rdata equal to the RAM contents.
3. MAX_WAIT=4; sin_req held while faw and far alternate requests every cycle -> sin granted no later than the 5th cycle after sin_req rose; wait_cnt returns to 0 after the grant.
4. faw (addr 2, 0xBEEF) and far (addr 2) requested in the same cycle -> faw_ack first, then far_ack; far_rdata=0xBEEF on far_rvalid.
5. Protocol violations: sin_req dropped before ack -> err=1 and stays 1. A separate run changes far_addr while waiting -> err=1. A reset pulse clears err to 0.
6. Two far reads granted back-to-back with faw interleaved, then reset asserted 1 cycle after the second far_ack (RD_LAT=2) -> no far_rvalid after reset; all outputs at reset values the cycle after reset is sampled.

Source files
------------

// File: rtl/chan_mem_arb.sv
// chan_mem_arb: arbiter for the single-port per-channel state RAM.
// faw > far > sin, with starvation promotion for sin and a registered RAM port.
module chan_mem_arb #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin_req,
  input  logic [ADDR_W-1:0] sin_addr,
  input  logic [DATA_W-1:0] sin_wdata,
  output logic              sin_ack,
  input  logic              far_req,
  input  logic [ADDR_W-1:0] far_addr,
  output logic              far_ack,
  output logic [DATA_W-1:0] far_rdata,
  output logic              far_rvalid,
  input  logic              faw_req,
  input  logic [ADDR_W-1:0] faw_addr,
  input  logic [DATA_W-1:0] faw_wdata,
  output logic              faw_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int WC_W = 4;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

  logic [WC_W-1:0]   wait_cnt;
  logic [RD_LAT-1:0] rv_pipe;

  logic sin_el, far_el, faw_el, promote;
  logic gnt_sin, gnt_far, gnt_faw;

  logic              sin_req_q, far_req_q, faw_req_q;
  logic              sin_ack_q, far_ack_q, faw_ack_q;
  logic [ADDR_W-1:0] sin_addr_q, far_addr_q, faw_addr_q;
  logic [DATA_W-1:0] sin_wdata_q, faw_wdata_q;
  logic              sin_bad, far_bad, faw_bad;

  assign far_rdata  = mem_rdata;
  assign far_rvalid = rv_pipe[RD_LAT-1];

  // A requester's req is still visible while its ack is high; mask it.
  always_comb begin
    sin_el  = sin_req & ~sin_ack;
    far_el  = far_req & ~far_ack;
    faw_el  = faw_req & ~faw_ack;
    promote = sin_el & (wait_cnt == WC_MAX);
    gnt_sin = 1'b0;
    gnt_far = 1'b0;
    gnt_faw = 1'b0;
    if (promote)
      gnt_sin = 1'b1;
    else if (faw_el)
      gnt_faw = 1'b1;
    else if (far_el)
      gnt_far = 1'b1;
    else if (sin_el)
      gnt_sin = 1'b1;
  end

  // Pending = held last cycle without an ack; it must neither
  // disappear nor change its payload.
  always_comb begin
    sin_bad = sin_req_q & ~sin_ack_q &
      ((~sin_req & ~sin_ack) |
       (sin_req & ((sin_addr != sin_addr_q) |
                   (sin_wdata != sin_wdata_q))));
    far_bad = far_req_q & ~far_ack_q &
      ((~far_req & ~far_ack) |
       (far_req & (far_addr != far_addr_q)));
    faw_bad = faw_req_q & ~faw_ack_q &
      ((~faw_req & ~faw_ack) |
       (faw_req & ((faw_addr != faw_addr_q) |
                   (faw_wdata != faw_wdata_q))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sin_ack     <= 1'b0;
      far_ack     <= 1'b0;
      faw_ack     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      rv_pipe     <= '0;
      err         <= 1'b0;
      sin_req_q   <= 1'b0;
      far_req_q   <= 1'b0;
      faw_req_q   <= 1'b0;
      sin_ack_q   <= 1'b0;
      far_ack_q   <= 1'b0;
      faw_ack_q   <= 1'b0;
      sin_addr_q  <= '0;
      far_addr_q  <= '0;
      faw_addr_q  <= '0;
      sin_wdata_q <= '0;
      faw_wdata_q <= '0;
    end else begin
      sin_ack <= gnt_sin;
      far_ack <= gnt_far;
      faw_ack <= gnt_faw;
      mem_en  <= gnt_sin | gnt_far | gnt_faw;
      mem_we  <= gnt_sin | gnt_faw;
      unique case (1'b1)
        gnt_faw: begin
          mem_addr  <= faw_addr;
          mem_wdata <= faw_wdata;
        end
        gnt_sin: begin
          mem_addr  <= sin_addr;
          mem_wdata <= sin_wdata;
        end
        gnt_far: mem_addr <= far_addr;
        default: ;
      endcase

      if (!sin_req || sin_ack || gnt_sin)
        wait_cnt <= '0;
      else if (wait_cnt != WC_MAX)
        wait_cnt <= wait_cnt + 1'b1;

      rv_pipe <= (rv_pipe << 1) | RD_LAT'(far_ack);
      err     <= err | sin_bad | far_bad | faw_bad;

      sin_req_q   <= sin_req;
      far_req_q   <= far_req;
      faw_req_q   <= faw_req;
      sin_ack_q   <= sin_ack;
      far_ack_q   <= far_ack;
      faw_ack_q   <= faw_ack;
      sin_addr_q  <= sin_addr;
      far_addr_q  <= far_addr;
      faw_addr_q  <= faw_addr;
      sin_wdata_q <= sin_wdata;
      faw_wdata_q <= faw_wdata;
    end
  end

endmodule

// File: tb/tb_chan_mem_arb.sv
// tb_chan_mem_arb: directed bench for chan_mem_arb.
// RD_LAT=2, MAX_WAIT=4, with a small behavioural RAM on the mem port.
module tb_chan_mem_arb;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int MW = 4;

  logic          clk;
  logic          reset;
  logic          sin_req, far_req, faw_req;
  logic [AW-1:0] sin_addr, far_addr, faw_addr;
  logic [DW-1:0] sin_wdata, faw_wdata;
  logic          sin_ack, far_ack, faw_ack;
  logic [DW-1:0] far_rdata;
  logic          far_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err;

  int errors = 0;
  int checks = 0;

  chan_mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .sin_req(sin_req), .sin_addr(sin_addr),
    .sin_wdata(sin_wdata), .sin_ack(sin_ack),
    .far_req(far_req), .far_addr(far_addr),
    .far_ack(far_ack), .far_rdata(far_rdata),
    .far_rvalid(far_rvalid),
    .faw_req(faw_req), .faw_addr(faw_addr),
    .faw_wdata(faw_wdata), .faw_ack(faw_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [8];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (mem_en && mem_we)
      ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we)
      rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RL; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RL-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sin_req = 0; far_req = 0; faw_req = 0;
    sin_addr = 0; far_addr = 0; faw_addr = 0;
    sin_wdata = 0; faw_wdata = 0;
    step();
    step();
    chk("rst_sin_ack", 32'(sin_ack), 0);
    chk("rst_far_ack", 32'(far_ack), 0);
    chk("rst_faw_ack", 32'(faw_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rvalid", 32'(far_rvalid), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // single serial write
    sin_req = 1; sin_addr = 5; sin_wdata = 16'h1234;
    step();
    chk("t1_sin_ack", 32'(sin_ack), 1);
    chk("t1_mem_en", 32'(mem_en), 1);
    chk("t1_mem_we", 32'(mem_we), 1);
    chk("t1_mem_addr", 32'(mem_addr), 5);
    chk("t1_mem_wdata", 32'(mem_wdata), 'h1234);
    step();
    chk("t1_once_en", 32'(mem_en), 0);
    chk("t1_once_ack", 32'(sin_ack), 0);
    chk("t1_addr_hold", 32'(mem_addr), 5);
    sin_req = 0;
    step();

    // all three at once: faw, far, sin
    faw_req = 1; faw_addr = 3; faw_wdata = 16'hA5A5;
    far_req = 1; far_addr = 5;
    sin_req = 1; sin_addr = 6; sin_wdata = 16'h0606;
    step();
    chk("t2_faw_ack", 32'(faw_ack), 1);
    chk("t2_c1_far_ack", 32'(far_ack), 0);
    chk("t2_c1_sin_ack", 32'(sin_ack), 0);
    chk("t2_c1_addr", 32'(mem_addr), 3);
    chk("t2_c1_wdata", 32'(mem_wdata), 'hA5A5);
    step();
    chk("t2_far_ack", 32'(far_ack), 1);
    chk("t2_c2_we", 32'(mem_we), 0);
    chk("t2_c2_addr", 32'(mem_addr), 5);
    chk("t2_c2_wdata_hold", 32'(mem_wdata), 'hA5A5);
    faw_req = 0;
    step();
    chk("t2_sin_ack", 32'(sin_ack), 1);
    chk("t2_c3_addr", 32'(mem_addr), 6);
    chk("t2_c3_wdata", 32'(mem_wdata), 'h0606);
    chk("t2_c3_rvalid", 32'(far_rvalid), 0);
    far_req = 0;
    step();
    chk("t2_rvalid", 32'(far_rvalid), 1);
    chk("t2_rdata", 32'(far_rdata), 'h1234);
    chk("t2_c4_en", 32'(mem_en), 0);
    sin_req = 0;
    step();
    chk("t2_rvalid_pulse", 32'(far_rvalid), 0);

    // sin starvation under continuous faw/far traffic
    sin_req = 1; sin_addr = 1; sin_wdata = 16'h1111;
    faw_req = 1; faw_addr = 0; faw_wdata = 16'h00F0;
    far_req = 1; far_addr = 0;
    step();
    chk("t3_c1_faw", 32'(faw_ack), 1);
    step();
    chk("t3_c2_far", 32'(far_ack), 1);
    step();
    chk("t3_c3_faw", 32'(faw_ack), 1);
    step();
    chk("t3_c4_far", 32'(far_ack), 1);
    chk("t3_c4_sin", 32'(sin_ack), 0);
    chk("t3_c4_wait", 32'(dut.wait_cnt), 4);
    step();
    chk("t3_c5_sin", 32'(sin_ack), 1);
    chk("t3_c5_faw", 32'(faw_ack), 0);
    chk("t3_c5_addr", 32'(mem_addr), 1);
    chk("t3_c5_wdata", 32'(mem_wdata), 'h1111);
    chk("t3_c5_wait", 32'(dut.wait_cnt), 0);
    step();
    chk("t3_c6_faw", 32'(faw_ack), 1);
    sin_req = 0;
    step();
    chk("t3_c7_far", 32'(far_ack), 1);
    faw_req = 0;
    step();
    far_req = 0;
    step();
    chk("t3_err", 32'(err), 0);

    // same-address write then read
    faw_req = 1; faw_addr = 2; faw_wdata = 16'hBEEF;
    far_req = 1; far_addr = 2;
    step();
    chk("t4_faw_first", 32'(faw_ack), 1);
    chk("t4_far_not_first", 32'(far_ack), 0);
    step();
    chk("t4_far_ack", 32'(far_ack), 1);
    chk("t4_far_addr", 32'(mem_addr), 2);
    faw_req = 0;
    step();
    chk("t4_c3_rvalid", 32'(far_rvalid), 0);
    far_req = 0;
    step();
    chk("t4_rvalid", 32'(far_rvalid), 1);
    chk("t4_rdata", 32'(far_rdata), 'hBEEF);
    step();

    // sin withdrawn before ack
    sin_req = 1; sin_addr = 4; sin_wdata = 16'h4444;
    faw_req = 1; faw_addr = 0; faw_wdata = 16'h0000;
    step();
    chk("t5a_c1_err", 32'(err), 0);
    sin_req = 0;
    step();
    chk("t5a_err_set", 32'(err), 1);
    faw_req = 0;
    step();
    step();
    chk("t5a_err_sticky", 32'(err), 1);
    reset = 1;
    step();
    chk("t5a_err_clr", 32'(err), 0);
    reset = 0;

    // far_addr changed while waiting
    faw_req = 1; faw_addr = 0; faw_wdata = 16'h0000;
    far_req = 1; far_addr = 1;
    step();
    chk("t5b_c1_err", 32'(err), 0);
    far_addr = 4;
    step();
    chk("t5b_err_set", 32'(err), 1);
    faw_req = 0;
    step();
    far_req = 0;
    reset = 1;
    step();
    chk("t5b_err_clr", 32'(err), 0);
    reset = 0;

    // far, faw, far, then reset kills the second read
    far_req = 1; far_addr = 3;
    step();
    chk("t6_c1_far", 32'(far_ack), 1);
    faw_req = 1; faw_addr = 7; faw_wdata = 16'h7777;
    step();
    chk("t6_c2_faw", 32'(faw_ack), 1);
    chk("t6_c2_far", 32'(far_ack), 0);
    step();
    chk("t6_c3_far", 32'(far_ack), 1);
    chk("t6_c3_rvalid", 32'(far_rvalid), 1);
    chk("t6_c3_rdata", 32'(far_rdata), 'hA5A5);
    faw_req = 0;
    step();
    chk("t6_c4_rvalid", 32'(far_rvalid), 0);
    chk("t6_c4_en", 32'(mem_en), 0);
    far_req = 0;
    reset = 1;
    step();
    chk("t6_rst_rvalid", 32'(far_rvalid), 0);
    chk("t6_rst_far_ack", 32'(far_ack), 0);
    chk("t6_rst_faw_ack", 32'(faw_ack), 0);
    chk("t6_rst_en", 32'(mem_en), 0);
    chk("t6_rst_we", 32'(mem_we), 0);
    chk("t6_rst_addr", 32'(mem_addr), 0);
    chk("t6_rst_wdata", 32'(mem_wdata), 0);
    chk("t6_rst_err", 32'(err), 0);
    reset = 0;
    step();
    chk("t6_c6_rvalid", 32'(far_rvalid), 0);
    step();
    chk("t6_c7_rvalid", 32'(far_rvalid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
